// File: rtl/sha_result_checker_pkg.sv
// Shared types and helpers for the double-SHA256 result checker:
// hash state layout, compact-difficulty expansion and hash byte ordering.
package sha_result_checker_pkg;

    // H0..H7, H0 occupies the most significant word of the packed vector.
    typedef logic [0:7][31:0] HashState;

    localparam int NONCE_W = 32;

    // Compact nBits -> 256-bit target; saturates to all-ones when the mantissa
    // would be shifted past bit 255.
    function automatic logic [255:0] compact_to_target(input logic [31:0] bits);
        logic [7:0]   e;
        logic [23:0]  m;
        logic [279:0] wide;
        logic [255:0] t;
        e    = bits[31:24];
        m    = bits[23:0];
        wide = '0;
        t    = '0;
        if (m[23] || (m == 24'd0)) begin
            t = '0;
        end else if (e <= 8'd3) begin
            t = 256'(m >> (8 * (3 - e)));
        end else if ((e - 8'd3) >= 8'd32) begin
            t = '1;
        end else begin
            wide = {256'd0, m} << (8 * (e - 8'd3));
            t    = (|wide[279:256]) ? '1 : wide[255:0];
        end
        return t;
    endfunction

    // Byte-reverse {H0..H7}: the last byte of H7 becomes the value's MSB.
    function automatic logic [255:0] hash_to_value(input HashState h);
        logic [255:0] s;
        logic [255:0] v;
        s = h;
        v = '0;
        for (int i = 0; i < 32; i++) begin
            v[8*i +: 8] = s[8*(31-i) +: 8];
        end
        return v;
    endfunction

endpackage

// File: rtl/sha_result_checker_fifo.sv
// Winning-nonce FIFO with valid/ready pop; a push while full succeeds only
// when a pop frees the head slot in the same cycle, otherwise it is dropped.
module sha_result_fifo
    import sha_result_checker_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = NONCE_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop_ready,
    output logic             pop_valid,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic             drop
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             pop;
    logic             wr_en;

    always_comb begin
        empty     = (wr_ptr_q == rd_ptr_q);
        full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        pop       = !empty && pop_ready;
        wr_en     = push && (!full || pop);
        drop      = push && full && !pop;
        pop_valid = !empty;
        pop_data  = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
        mem_d     = mem_q;
        if (wr_en) begin
            mem_d[wr_ptr_q[AW-1:0]] = push_data;
        end
        wr_ptr_d  = wr_ptr_q + (AW+1)'(wr_en);
        rd_ptr_d  = rd_ptr_q + (AW+1)'(pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/sha_result_checker.sv
// Checks each double hash against the block target, tags it with its nonce
// and queues winning nonces for the host.
module sha_result_checker
    import sha_result_checker_pkg::*;
#(
    parameter logic [31:0] PROCESSORINDEX = 32'd0,
    parameter logic [31:0] NUMPROCESSORS  = 32'd1,
    parameter int          FIFO_DEPTH     = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hash_valid,
    input  logic        newblock_i,
    input  HashState    doublehash,
    input  logic [31:0] difficulty,
    output logic        result_valid,
    input  logic        result_ready,
    output logic [31:0] result_nonce,
    output logic        overflow,
    output logic        exhausted,
    output logic [31:0] hits
);
    logic [31:0]  cnt_q, cnt_d;
    logic         exhausted_q, exhausted_d;
    logic         valid_s0_q, valid_s0_d;
    logic         nb_s0_q, nb_s0_d;
    logic [31:0]  nonce_s0_q, nonce_s0_d;
    logic [255:0] val_s0_q, val_s0_d;
    logic [255:0] tgt_s0_q, tgt_s0_d;
    logic         hit_s1_q, hit_s1_d;
    logic         nb_s1_q, nb_s1_d;
    logic [31:0]  nonce_s1_q, nonce_s1_d;
    logic         overflow_q, overflow_d;
    logic [31:0]  hits_q, hits_d;

    logic [31:0]  nonce_sel;
    logic [31:0]  cnt_next;
    logic         carry;
    logic         fifo_full;
    logic         fifo_empty;
    logic         fifo_drop;

    always_comb begin
        nonce_sel         = newblock_i ? PROCESSORINDEX : cnt_q;
        {carry, cnt_next} = {1'b0, nonce_sel} + {1'b0, NUMPROCESSORS};

        cnt_d       = cnt_q;
        exhausted_d = exhausted_q;
        valid_s0_d  = hash_valid;
        nb_s0_d     = hash_valid && newblock_i;
        nonce_s0_d  = nonce_s0_q;
        val_s0_d    = val_s0_q;
        tgt_s0_d    = tgt_s0_q;
        if (hash_valid) begin
            cnt_d       = cnt_next;
            nonce_s0_d  = nonce_sel;
            val_s0_d    = hash_to_value(doublehash);
            tgt_s0_d    = compact_to_target(difficulty);
            exhausted_d = newblock_i ? 1'b0 : (exhausted_q | carry);
        end

        hit_s1_d   = valid_s0_q && (val_s0_q <= tgt_s0_q);
        nb_s1_d    = valid_s0_q && nb_s0_q;
        nonce_s1_d = nonce_s0_q;

        // Block statistics restart when the newblock hash reaches the push
        // stage, so hits still in flight from the old block are not miscounted.
        if (nb_s1_q) begin
            hits_d     = {31'd0, hit_s1_q};
            overflow_d = fifo_drop;
        end else begin
            hits_d     = hits_q + 32'(hit_s1_q && (hits_q != '1));
            overflow_d = overflow_q | fifo_drop;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q       <= PROCESSORINDEX;
            exhausted_q <= 1'b0;
            valid_s0_q  <= 1'b0;
            nb_s0_q     <= 1'b0;
            nonce_s0_q  <= '0;
            val_s0_q    <= '0;
            tgt_s0_q    <= '0;
            hit_s1_q    <= 1'b0;
            nb_s1_q     <= 1'b0;
            nonce_s1_q  <= '0;
            overflow_q  <= 1'b0;
            hits_q      <= '0;
        end else begin
            cnt_q       <= cnt_d;
            exhausted_q <= exhausted_d;
            valid_s0_q  <= valid_s0_d;
            nb_s0_q     <= nb_s0_d;
            nonce_s0_q  <= nonce_s0_d;
            val_s0_q    <= val_s0_d;
            tgt_s0_q    <= tgt_s0_d;
            hit_s1_q    <= hit_s1_d;
            nb_s1_q     <= nb_s1_d;
            nonce_s1_q  <= nonce_s1_d;
            overflow_q  <= overflow_d;
            hits_q      <= hits_d;
        end
    end

    sha_result_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (hit_s1_q),
        .push_data (nonce_s1_q),
        .pop_ready (result_ready),
        .pop_valid (result_valid),
        .pop_data  (result_nonce),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .drop      (fifo_drop)
    );

    assign overflow  = overflow_q;
    assign exhausted = exhausted_q;
    assign hits      = hits_q;

endmodule
